// File: rtl/acc_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// acc_issue_ctrl_pkg
//   Shared definitions for the accumulator issue path (the mac_defs set):
//   the FP32 zero constant used for padding, and the issue FSM state
//   encodings (IDLE / DRAIN / PAD).
//   No ports; imported by acc_issue_ctrl and acc_issue_ctrl_pointer.
// ---------------------------------------------------------------------------
package acc_issue_ctrl_pkg;

    // Positive zero in IEEE-754 single precision; adding it leaves a sum unchanged.
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PAD   = 2'd2
    } issue_state_e;

    // A flush is in progress in any state other than IDLE.
    function automatic logic state_is_busy(input issue_state_e state);
        return state != ST_IDLE;
    endfunction

endpackage : acc_issue_ctrl_pkg

// File: rtl/acc_issue_ctrl_pointer.sv
// ---------------------------------------------------------------------------
// acc_issue_ctrl_pointer
//   Wrapping up-counter used for the FIFO write/read pointers and the
//   accumulation group counter. Counts 0..Max and wraps back to 0.
// Ports:
//   clk    in   rising-edge clock
//   aclr   in   asynchronous reset, active-high (clears to 0)
//   sclr   in   synchronous clear (wins over en)
//   en     in   advance by one this cycle
//   value  out  current count (registered)
// ---------------------------------------------------------------------------
module acc_issue_ctrl_pointer
    import acc_issue_ctrl_pkg::*;
#(
    parameter int Width = 2,
    parameter int Max   = 3
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             en,
    output logic [Width-1:0] value
);

    localparam logic [Width-1:0] MAX_VALUE = Width'(Max);

    logic [Width-1:0] value_d;
    logic [Width-1:0] value_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (sclr) begin
            value_d = '0;
        end else if (en) begin
            value_d = (value_q == MAX_VALUE) ? '0 : value_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : acc_issue_ctrl_pointer

// File: rtl/acc_issue_ctrl.sv
// ---------------------------------------------------------------------------
// acc_issue_ctrl
//   Transmit side of the accumulator input handshake. Buffers operands from
//   the multiplier stage in a 2**BufferWidth deep FIFO and issues one per
//   accepted beat to the accumulator. Tracks the position inside the current
//   accumulation group (modulo AccumulateCount) and pulses GroupDone the
//   cycle after the last operand of a group has transferred.
//
// Optional feature (compile-time macro ACC_ISSUE_ZERO_PAD_EN):
//   defined     - Flush drains the FIFO and then pads the open group with
//                 +0.0 words so the accumulator sees a complete group.
//   not defined - Flush is ignored, FlushBusy is 0, a partial group waits
//                 for more data.
//
// Ports:
//   clk           in   rising-edge clock
//   aclr          in   asynchronous reset, active-high
//   PushValid     in   upstream operand valid
//   PushData      in   upstream operand
//   PushRdy       out  FIFO can accept (not full and not flushing)
//   Flush         in   pulse: finish the current (partial) group
//   DataOutValid  out  operand available to the accumulator
//   DataOutRdy    in   accumulator ready
//   DataOut       out  operand to the accumulator
//   GroupDone     out  1-cycle pulse after a group's last operand transfers
//   FlushBusy     out  high while a flush is in progress
// ---------------------------------------------------------------------------
module acc_issue_ctrl
    import acc_issue_ctrl_pkg::*;
#(
    parameter int DataWidth            = 32,
    parameter int BufferWidth          = 2,
    parameter int AccumulateCount      = 2,
    parameter int AccumulateCountWidth = 1
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 PushValid,
    input  logic [DataWidth-1:0] PushData,
    output logic                 PushRdy,
    input  logic                 Flush,
    output logic                 DataOutValid,
    input  logic                 DataOutRdy,
    output logic [DataWidth-1:0] DataOut,
    output logic                 GroupDone,
    output logic                 FlushBusy
);

    localparam int DEPTH   = 2 ** BufferWidth;
    localparam int CNT_W   = BufferWidth + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [AccumulateCountWidth-1:0] GROUP_LAST =
        AccumulateCountWidth'(AccumulateCount - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    issue_state_e                  state_d;
    issue_state_e                  state_q;
    logic [CNT_W-1:0]              count_d;
    logic [CNT_W-1:0]              count_q;
    logic                          group_done_d;
    logic                          group_done_q;
    logic [DataWidth-1:0]          mem_q [DEPTH];

    logic [BufferWidth-1:0]          wptr;
    logic [BufferWidth-1:0]          rptr;
    logic [AccumulateCountWidth-1:0] group_cnt;

    // -----------------------------------------------------------------------
    // Handshake decode (registered state only, so full never opens a slot
    // in the same cycle as a pop)
    // -----------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic padding;
    logic push;
    logic transfer;
    logic fifo_pop;
    logic group_wrap;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign padding    = (state_q == ST_PAD);

    assign PushRdy      = !fifo_full && (state_q == ST_IDLE);
    assign DataOutValid = padding || !fifo_empty;
    assign FlushBusy    = state_is_busy(state_q);
    assign GroupDone    = group_done_q;

    // Pad words come from the constant, not storage; outside a valid beat the
    // output is parked at zero so stale memory never shows on the bus.
    assign DataOut = padding        ? DataWidth'(FP32_ZERO) :
                     !fifo_empty    ? mem_q[rptr]           :
                                      '0;

    assign push       = PushValid && PushRdy;
    assign transfer   = DataOutValid && DataOutRdy;
    assign fifo_pop   = transfer && !padding;
    assign group_wrap = transfer && (group_cnt == GROUP_LAST);

    // -----------------------------------------------------------------------
    // Pointers and group counter
    // -----------------------------------------------------------------------
    acc_issue_ctrl_pointer #(
        .Width (BufferWidth),
        .Max   (DEPTH - 1)
    ) u_wptr (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (1'b0),
        .en    (push),
        .value (wptr)
    );

    acc_issue_ctrl_pointer #(
        .Width (BufferWidth),
        .Max   (DEPTH - 1)
    ) u_rptr (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (1'b0),
        .en    (fifo_pop),
        .value (rptr)
    );

    acc_issue_ctrl_pointer #(
        .Width (AccumulateCountWidth),
        .Max   (AccumulateCount - 1)
    ) u_group_cnt (
        .clk   (clk),
        .aclr  (aclr),
        .sclr  (group_wrap),
        .en    (transfer),
        .value (group_cnt)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        count_d      = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
        group_done_d = group_wrap;
    end

`ifdef ACC_ISSUE_ZERO_PAD_EN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Decide only once the FIFO is really empty; the group counter
                // then already reflects the last drained transfer.
                if (fifo_empty) begin
                    state_d = (group_cnt != '0) ? ST_PAD : ST_IDLE;
                end
            end
            ST_PAD: begin
                if (group_wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`else
    // Without padding the controller never leaves IDLE and Flush has no effect.
    logic unused_flush;
    assign unused_flush = Flush;

    always_comb begin
        state_d = ST_IDLE;
    end
`endif

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            group_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            group_done_q <= group_done_d;
        end
    end

    // NOTE: the storage array has no reset; the occupancy counter defines which
    // entries are meaningful, so clearing the words would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr] <= PushData;
        end
    end

endmodule : acc_issue_ctrl
